rete_arb: RTL and testbench

RETE_ARB -- requirements
Module: rete_arb

---
 rtl/rete_arb.sv | 125 ++++++++++++
 tb/tb_rete_arb.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/rete_arb.sv
// Round-robin arbiter sharing one combinational network among N_REQ requesters.
// Optional RETE_ARB_CHECK_EN adds err: result check against a NAND golden value.
module rete_arb #(
  parameter int N_REQ  = 4,
  parameter int SETTLE = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [N_REQ-1:0] req,
  input  logic [N_REQ-1:0] a_in,
  input  logic [N_REQ-1:0] b_in,
  output logic [N_REQ-1:0] gnt,
  output logic [N_REQ-1:0] done,
  output logic             res,
  output logic             net_a,
  output logic             net_b,
  input  logic             net_c,
  output logic             busy
`ifdef RETE_ARB_CHECK_EN
  ,
  output logic             err
`endif
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EVAL = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [IW-1:0] k_q, k_d;
  logic [IW-1:0] last_q, last_d;
  logic          a_q, a_d;
  logic          b_q, b_d;
  logic          res_q, res_d;
  logic [IW-1:0] win;

  // Search starts just past the last served index.
  always_comb begin
    int idx;
    logic found;
    win   = '0;
    found = 1'b0;
    idx   = 0;
    for (int i = 0; i < N_REQ; i++) begin
      idx = (int'(last_q) + 1 + i) % N_REQ;
      if (!found && req[idx]) begin
        found = 1'b1;
        win   = IW'(idx);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    k_d     = k_q;
    last_d  = last_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    unique case (1'b1)
      (state_q == IDLE): begin
        if (|req) begin
          state_d = EVAL;
          k_d     = win;
          a_d     = a_in[win];
          b_d     = b_in[win];
          cnt_d   = '0;
        end
      end
      (state_q == EVAL): begin
        if (cnt_q == 4'(SETTLE - 1)) begin
          state_d = RESP;
          res_d   = net_c;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      (state_q == RESP): begin
        state_d = IDLE;
        last_d  = k_q;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      k_q     <= '0;
      last_q  <= IW'(N_REQ - 1);
      a_q     <= 1'b0;
      b_q     <= 1'b0;
      res_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      k_q     <= k_d;
      last_q  <= last_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
    end
  end

  logic [N_REQ-1:0] onehot;
  assign onehot = {{(N_REQ-1){1'b0}}, 1'b1} << k_q;

  assign gnt   = (state_q == EVAL) ? onehot : '0;
  assign done  = (state_q == RESP) ? onehot : '0;
  assign net_a = (state_q == EVAL) & a_q;
  assign net_b = (state_q == EVAL) & b_q;
  assign busy  = (state_q != IDLE);
  assign res   = res_q;

`ifdef RETE_ARB_CHECK_EN
  assign err = (state_q == RESP) & (res_q != ~(a_q & b_q));
`endif

endmodule

// File: tb/tb_rete_arb.sv
// Directed table-driven bench for rete_arb with a NAND network model.
// Hand sequences cover contention rotation and the optional error check.
module tb_rete_arb;

  logic       clock = 1'b0;
  logic       reset;
  logic [3:0] req, a_in, b_in;
  logic [3:0] gnt, done;
  logic       res, net_a, net_b, net_c, busy;
  logic       force_en, force_val;
`ifdef RETE_ARB_CHECK_EN
  logic       err;
`endif

  int ncmp = 0;
  int nbad = 0;

  always #5 clock = ~clock;

  assign net_c = force_en ? force_val : ~(net_a & net_b);

  rete_arb #(.N_REQ(4), .SETTLE(2)) dut (
    .clock(clock),
    .reset(reset),
    .req(req),
    .a_in(a_in),
    .b_in(b_in),
    .gnt(gnt),
    .done(done),
    .res(res),
    .net_a(net_a),
    .net_b(net_b),
    .net_c(net_c),
    .busy(busy)
`ifdef RETE_ARB_CHECK_EN
    ,
    .err(err)
`endif
  );

  typedef struct {
    logic       rst;
    logic [3:0] req;
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] gnt;
    logic [3:0] done;
    logic       res;
    logic       busy;
    logic       na;
    logic       nb;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string nm, input int row,
                     input logic [3:0] act, input logic [3:0] exp);
    ncmp++;
    if (act !== exp) begin
      nbad++;
      $display("FAIL %s row %0d: got %h expected %h", nm, row, act, exp);
    end
  endtask

  task automatic step(input logic r, input logic [3:0] q,
                      input logic [3:0] a, input logic [3:0] b);
    reset = r;
    req   = q;
    a_in  = a;
    b_in  = b;
    @(posedge clock);
    #1;
  endtask

  task automatic add(input logic r, input logic [3:0] q, a, b, g, d,
                     input logic rs, bs, na, nb);
    tbl.push_back('{r, q, a, b, g, d, rs, bs, na, nb});
  endtask

  initial begin
    reset = 1'b1; req = '0; a_in = '0; b_in = '0;
    force_en = 1'b0; force_val = 1'b0;
    #1;
    // rst req a b | gnt done res busy na nb
    add(1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 0, 0, 0, 0);
    add(0, 4'h1, 4'h1, 4'h1, 4'h1, 4'h0, 0, 1, 1, 1);
    add(0, 4'h0, 4'h1, 4'h1, 4'h1, 4'h0, 0, 1, 1, 1);
    add(0, 4'h0, 4'h1, 4'h1, 4'h0, 4'h1, 0, 1, 0, 0);
    add(0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 0, 0, 0, 0);
    add(0, 4'h4, 4'h4, 4'h4, 4'h4, 4'h0, 0, 1, 1, 1);
    add(0, 4'h0, 4'h0, 4'h4, 4'h4, 4'h0, 0, 1, 1, 1);
    add(0, 4'h0, 4'h0, 4'h4, 4'h0, 4'h4, 0, 1, 0, 0);
    add(0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 0, 0, 0, 0);
    add(0, 4'h8, 4'h0, 4'h0, 4'h8, 4'h0, 0, 1, 0, 0);
    add(0, 4'h0, 4'h0, 4'h0, 4'h8, 4'h0, 0, 1, 0, 0);
    add(0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h8, 1, 1, 0, 0);
    add(0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 1, 0, 0, 0);
    add(0, 4'h2, 4'h2, 4'h0, 4'h2, 4'h0, 1, 1, 1, 0);
    add(0, 4'h0, 4'h2, 4'h0, 4'h2, 4'h0, 1, 1, 1, 0);
    add(0, 4'h0, 4'h2, 4'h0, 4'h0, 4'h2, 1, 1, 0, 0);
    add(0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 1, 0, 0, 0);
    add(0, 4'h3, 4'h0, 4'h0, 4'h1, 4'h0, 1, 1, 0, 0);
    add(0, 4'h3, 4'h0, 4'h0, 4'h1, 4'h0, 1, 1, 0, 0);
    add(0, 4'h3, 4'h0, 4'h0, 4'h0, 4'h1, 1, 1, 0, 0);
    add(0, 4'h3, 4'h0, 4'h0, 4'h0, 4'h0, 1, 0, 0, 0);
    add(0, 4'h3, 4'h0, 4'h0, 4'h2, 4'h0, 1, 1, 0, 0);
    add(0, 4'h0, 4'h0, 4'h0, 4'h2, 4'h0, 1, 1, 0, 0);
    add(0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h2, 1, 1, 0, 0);
    add(0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 1, 0, 0, 0);
    add(0, 4'h1, 4'h0, 4'h0, 4'h1, 4'h0, 1, 1, 0, 0);
    add(0, 4'h0, 4'h0, 4'h0, 4'h1, 4'h0, 1, 1, 0, 0);
    add(0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h1, 1, 1, 0, 0);
    add(0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 1, 0, 0, 0);
    add(0, 4'h3, 4'h0, 4'h0, 4'h2, 4'h0, 1, 1, 0, 0);
    add(1, 4'h3, 4'h0, 4'h0, 4'h0, 4'h0, 0, 0, 0, 0);
    add(0, 4'h3, 4'h0, 4'h0, 4'h1, 4'h0, 0, 1, 0, 0);
    add(0, 4'h0, 4'h0, 4'h0, 4'h1, 4'h0, 0, 1, 0, 0);
    add(0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h1, 1, 1, 0, 0);
    add(0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 1, 0, 0, 0);

    foreach (tbl[i]) begin
      step(tbl[i].rst, tbl[i].req, tbl[i].a, tbl[i].b);
      chk("gnt",   i, gnt,            tbl[i].gnt);
      chk("done",  i, done,           tbl[i].done);
      chk("res",   i, {3'b0, res},    {3'b0, tbl[i].res});
      chk("busy",  i, {3'b0, busy},   {3'b0, tbl[i].busy});
      chk("net_a", i, {3'b0, net_a},  {3'b0, tbl[i].na});
      chk("net_b", i, {3'b0, net_b},  {3'b0, tbl[i].nb});
    end

    // Full contention after reset: one done every 4 cycles, rotating.
    step(1, 4'h0, 4'h0, 4'h0);
    for (int c = 1; c <= 16; c++) begin
      logic [3:0] ed;
      ed = (c % 4 == 3) ? (4'h1 << (c / 4)) : 4'h0;
      step(0, 4'hF, 4'h0, 4'h0);
      chk("rr_done", c, done, ed);
    end
    step(1, 4'h0, 4'h0, 4'h0);
    chk("rr_rst_busy", 0, {3'b0, busy}, 4'h0);

`ifdef RETE_ARB_CHECK_EN
    for (int p = 0; p < 2; p++) begin
      force_en  = 1'b1;
      force_val = (p == 1);
      step(1, 4'h0, 4'h0, 4'h0);
      chk("err_rst", p, {3'b0, err}, 4'h0);
      step(0, 4'h1, 4'h0, 4'h0);
      step(0, 4'h0, 4'h0, 4'h0);
      chk("err_eval", p, {3'b0, err}, 4'h0);
      step(0, 4'h0, 4'h0, 4'h0);
      chk("err_resp", p, {3'b0, err}, (p == 0) ? 4'h1 : 4'h0);
      chk("err_done", p, done, 4'h1);
      step(0, 4'h0, 4'h0, 4'h0);
      chk("err_idle", p, {3'b0, err}, 4'h0);
    end
    force_en = 1'b0;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nbad);
    $finish;
  end

endmodule
